// File: rtl/vector_alu_pkg.sv
// Shared opcodes and sequencer state encoding for the vector ALU execute stage.
package vector_alu_pkg;

  localparam logic [2:0] OP_ZERO = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_INC  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/vector_alu_sequencer_if.sv
// Issue-side and writeback-side handshake bundle of the vector ALU sequencer.
interface vector_alu_sequencer_if #(
  parameter int unsigned dataSize = 8,
  parameter int unsigned lanes    = 4
);

  logic                        in_valid;
  logic                        in_ready;
  logic [2:0]                  op;
  logic [lanes*dataSize-1:0]   vec_a;
  logic [lanes*dataSize-1:0]   vec_b;
  logic [lanes-1:0]            lane_mask;
  logic                        out_valid;
  logic                        out_ready;
  logic [lanes*dataSize-1:0]   vec_result;
  logic [lanes-1:0]            neg_flags;
  logic [lanes-1:0]            zero_flags;
  logic                        busy;

  modport master (
    output in_valid, op, vec_a, vec_b, lane_mask, out_ready,
    input  in_ready, out_valid, vec_result, neg_flags, zero_flags, busy
  );

  modport slave (
    input  in_valid, op, vec_a, vec_b, lane_mask, out_ready,
    output in_ready, out_valid, vec_result, neg_flags, zero_flags, busy
  );

endinterface

// File: rtl/alu.sv
// Scalar ALU: one element per call, wrapping arithmetic, sign-change and zero flags.
module alu
  import vector_alu_pkg::*;
#(
  parameter int unsigned dataSize = 8
) (
  input  logic [2:0]          i_op,
  input  logic [dataSize-1:0] i_a,
  input  logic [dataSize-1:0] i_b,
  output logic [dataSize-1:0] o_result,
  output logic                o_neg_flag,
  output logic                o_zero_flag
);

  logic [dataSize-1:0] w_result;

  always_comb begin
    w_result = '0;
    case (i_op)
      OP_ZERO: w_result = '0;
      OP_XOR:  w_result = i_a ^ i_b;
      OP_ADD:  w_result = i_a + i_b;
      OP_SUB:  w_result = i_a - i_b;
      OP_MUL:  w_result = i_a * i_b;
      OP_SRL:  w_result = i_a >> i_b;
      OP_SLL:  w_result = i_a << i_b;
      OP_INC:  w_result = i_a + dataSize'(1);
      default: w_result = '0;
    endcase
  end

  assign o_result    = w_result;
  assign o_zero_flag = (w_result == '0);
  // "neg" flags a sign change between operand a and the result.
  assign o_neg_flag  = (i_a[dataSize-1] != w_result[dataSize-1]) && !o_zero_flag;

endmodule

// File: rtl/vector_alu_sequencer.sv
// Runs one vector op by feeding a single scalar ALU one lane per cycle, fixed latency.
module vector_alu_sequencer
  import vector_alu_pkg::*;
#(
  parameter int unsigned dataSize = 8,
  parameter int unsigned lanes    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  vector_alu_sequencer_if.slave  bus
);

  localparam int unsigned idxW = $clog2(lanes);
  localparam int unsigned VecW = lanes * dataSize;
  localparam logic [idxW-1:0] LastLane = idxW'(lanes - 1);

  seq_state_t          r_state;
  seq_state_t          w_state_next;
  logic [idxW-1:0]     r_lane_idx;
  logic [2:0]          r_op;
  logic [VecW-1:0]     r_a;
  logic [VecW-1:0]     r_b;
  logic [lanes-1:0]    r_mask;
  logic [VecW-1:0]     r_result;
  logic [lanes-1:0]    r_neg;
  logic [lanes-1:0]    r_zero;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_last_lane;
  logic [dataSize-1:0] w_a_lane;
  logic [dataSize-1:0] w_b_lane;
  logic [dataSize-1:0] w_alu_result;
  logic                w_alu_neg;
  logic                w_alu_zero;

  assign w_in_ready  = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready && !flush;
  assign w_last_lane = (r_lane_idx == LastLane);
  assign w_a_lane    = r_a[r_lane_idx*dataSize +: dataSize];
  assign w_b_lane    = r_b[r_lane_idx*dataSize +: dataSize];

  alu #(
    .dataSize(dataSize)
  ) u_alu (
    .i_op       (r_op),
    .i_a        (w_a_lane),
    .i_b        (w_b_lane),
    .o_result   (w_alu_result),
    .o_neg_flag (w_alu_neg),
    .o_zero_flag(w_alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_state_next = RUN;
      RUN:  if (w_last_lane) w_state_next = DONE;
      DONE: begin
        // A same-cycle accept in DONE restarts with no bubble.
        if (w_accept) begin
          w_state_next = RUN;
        end else if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (flush) w_state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane_idx <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_mask     <= '0;
      r_result   <= '0;
      r_neg      <= '0;
      r_zero     <= '0;
    end else if (flush) begin
      r_lane_idx <= '0;
      r_result   <= '0;
      r_neg      <= '0;
      r_zero     <= '0;
    end else if (w_accept) begin
      r_lane_idx <= '0;
      r_op       <= bus.op;
      r_a        <= bus.vec_a;
      r_b        <= bus.vec_b;
      r_mask     <= bus.lane_mask;
      r_result   <= '0;
      r_neg      <= '0;
      r_zero     <= '0;
    end else if (r_state == RUN) begin
      // Masked lanes pass operand a through with cleared flags.
      if (r_mask[r_lane_idx]) begin
        r_result[r_lane_idx*dataSize +: dataSize] <= w_alu_result;
        r_neg[r_lane_idx]                         <= w_alu_neg;
        r_zero[r_lane_idx]                        <= w_alu_zero;
      end else begin
        r_result[r_lane_idx*dataSize +: dataSize] <= w_a_lane;
        r_neg[r_lane_idx]                         <= 1'b0;
        r_zero[r_lane_idx]                        <= 1'b0;
      end
      r_lane_idx <= w_last_lane ? '0 : r_lane_idx + idxW'(1);
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_state == DONE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.vec_result = r_result;
  assign bus.neg_flags  = r_neg;
  assign bus.zero_flags = r_zero;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Directed and random checks of vector_alu_sequencer against a lane-by-lane arithmetic model.
module tb_vector_alu_sequencer;
  import vector_alu_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned LN = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  vector_alu_sequencer_if #(.dataSize(DW), .lanes(LN)) bus ();

  vector_alu_sequencer #(
    .dataSize(DW),
    .lanes   (LN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] m, output logic [31:0] r,
                                output logic [3:0] n, output logic [3:0] z);
    r = '0;
    n = '0;
    z = '0;
    for (int i = 0; i < LN; i++) begin
      int unsigned x, y, v;
      x = 32'((a >> (i * DW)) & 32'hFF);
      y = 32'((b >> (i * DW)) & 32'hFF);
      case (op)
        3'd0:    v = 0;
        3'd1:    v = x ^ y;
        3'd2:    v = x + y;
        3'd3:    v = x + 256 - y;
        3'd4:    v = x * y;
        3'd5:    v = (y >= DW) ? 0 : (x >> y);
        3'd6:    v = (y >= DW) ? 0 : (x << y);
        default: v = x + 1;
      endcase
      v = v % 256;
      if (m[i]) begin
        r    = r | (v << (i * DW));
        z[i] = (v == 0);
        n[i] = (v != 0) && ((x >= 128) != (v >= 128));
      end else begin
        r = r | (x << (i * DW));
      end
    end
  endfunction

  // Present an op at a negedge; returns one negedge after the accepting edge.
  task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] m);
    int w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_start", 32'(bus.in_ready), 32'd1);
    bus.op = op;
    bus.vec_a = a;
    bus.vec_b = b;
    bus.lane_mask = m;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LN));
  endtask

  task automatic check_result(input string tag, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] m);
    logic [31:0] r;
    logic [3:0]  n, z;
    model(op, a, b, m, r, n, z);
    check({tag, "_result"}, bus.vec_result, r);
    check({tag, "_neg"}, 32'(bus.neg_flags), 32'(n));
    check({tag, "_zero"}, 32'(bus.zero_flags), 32'(z));
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] m);
    logic [31:0] held;
    start(op, a, b, m);
    wait_done(tag);
    check_result(tag, op, a, b, m);
    held = bus.vec_result;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle_hold"}, bus.vec_result, held);
  endtask

  initial begin
    logic [31:0] ra, rb, held;
    logic [2:0]  rop;
    logic [3:0]  rm;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.vec_a = '0;
    bus.vec_b = '0;
    bus.lane_mask = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", bus.vec_result, 32'd0);
    check("rst_flags", {24'd0, bus.neg_flags, bus.zero_flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_op("add", OP_ADD, 32'h04030201, 32'h01010101, 4'hF);
    check("add_literal", bus.vec_result, 32'h05040302);
    run_op("sub", OP_SUB, 32'h00000105, 32'h00000205, 4'h3);
    check("sub_literal", bus.vec_result, 32'h0000FF00);
    run_op("xor", OP_XOR, 32'hAA55AA55, 32'hFFFFFFFF, 4'b0101);
    check("xor_literal", bus.vec_result, 32'hAAAAAAAA);
    run_op("zero", OP_ZERO, $urandom, $urandom, 4'hF);
    check("zero_flags_all", 32'(bus.zero_flags), 32'hF);

    // Hold in DONE, then back-to-back accept of an inc.
    rb = $urandom;
    start(OP_MUL, 32'h10203040, 32'h03020100, 4'hF);
    wait_done("hold");
    held = bus.vec_result;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_result", bus.vec_result, held);
    end
    bus.out_ready = 1'b1;
    bus.op = OP_INC;
    bus.vec_a = 32'h000000FF;
    bus.vec_b = rb;
    bus.lane_mask = 4'hF;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_busy", 32'(bus.busy), 32'd1);
    check("b2b_valid", 32'(bus.out_valid), 32'd0);
    wait_done("b2b");
    check_result("b2b", OP_INC, 32'h000000FF, rb, 4'hF);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Asynchronous reset in RUN at lane 2.
    start(OP_ADD, 32'h11223344, 32'h01010101, 4'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_result", bus.vec_result, 32'd0);
    check("mid_rst_flags", {24'd0, bus.neg_flags, bus.zero_flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Flush in RUN with a concurrent in_valid.
    start(OP_SUB, 32'h80808080, 32'h01010101, 4'hF);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    bus.op = OP_ADD;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_result", bus.vec_result, 32'd0);
    check("flush_flags", {24'd0, bus.neg_flags, bus.zero_flags}, 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    // Flush wins over a ready accept in IDLE too.
    @(negedge clk);
    check("flush_idle_busy", 32'(bus.busy), 32'd0);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_after_busy", 32'(bus.busy), 32'd0);

    for (int t = 0; t < 24; t++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (rop == OP_SRL || rop == OP_SLL) ? {4{8'($urandom_range(0, 9))}} : $urandom;
      rm  = 4'($urandom);
      run_op("rand", rop, ra, rb, rm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
